clk_freq_monitor: RTL

//  Multi-channel clock frequency monitor for PLL/DLL bring-up and self-test.

---
 rtl/clk_freq_monitor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/clk_freq_monitor.sv
// Multi-channel clock frequency monitor: counts mon_in edges over a window of
// reference cycles and range-checks each count. Optional irq via CLK_MON_IRQ_EN.
module clk_freq_monitor #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int WIN_W  = 16
) (
   input  logic                    clock,
   input  logic                    resetb,
   input  logic                    start,
   input  logic                    abort,
   input  logic [WIN_W-1:0]        window_len,
   input  logic [NUM_CH-1:0]       mon_in,
   input  logic [NUM_CH*CNT_W-1:0] thresh_lo,
   input  logic [NUM_CH*CNT_W-1:0] thresh_hi,
`ifdef CLK_MON_IRQ_EN
   input  logic                    irq_clr,
   output logic                    irq,
`endif
   output logic                    busy,
   output logic                    done,
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic [NUM_CH-1:0]       in_range,
   output logic [NUM_CH-1:0]       overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_COUNT,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [NUM_CH-1:0] s1_q, s2_q, s3_q;
   logic [NUM_CH-1:0] rise;

   logic [WIN_W-1:0] win_q, win_d;
   logic [WIN_W-1:0] wcnt_q, wcnt_d;

   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]            ovf_q, ovf_d;

   logic [NUM_CH-1:0][CNT_W-1:0] res_cnt_q, res_cnt_d;
   logic [NUM_CH-1:0]            res_ovf_q, res_ovf_d;
   logic [NUM_CH-1:0]            res_rng_q, res_rng_d;

   logic fin;

   // mon_in is asynchronous; two flops for metastability, third for edge detect
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= mon_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= S_IDLE;
         win_q     <= '0;
         wcnt_q    <= '0;
         cnt_q     <= '0;
         ovf_q     <= '0;
         res_cnt_q <= '0;
         res_ovf_q <= '0;
         res_rng_q <= '0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         wcnt_q    <= wcnt_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         res_cnt_q <= res_cnt_d;
         res_ovf_q <= res_ovf_d;
         res_rng_q <= res_rng_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      wcnt_d    = wcnt_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      res_cnt_d = res_cnt_q;
      res_ovf_d = res_ovf_q;
      res_rng_d = res_rng_q;
      fin       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_ARM;
               win_d   = (window_len == '0) ? WIN_W'(1) : window_len;
            end
         end
         S_ARM: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = '0;
               ovf_d   = '0;
               wcnt_d  = '0;
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + WIN_W'(1);
               for (int i = 0; i < NUM_CH; i++) begin
                  if (rise[i]) begin
                     if (&cnt_q[i]) ovf_d[i] = 1'b1;
                     else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
               if (wcnt_q == win_q - WIN_W'(1)) begin
                  state_d = S_DONE;
                  fin     = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Results include the edge seen in the final COUNT cycle
      if (fin) begin
         for (int i = 0; i < NUM_CH; i++) begin
            res_cnt_d[i] = cnt_d[i];
            res_ovf_d[i] = ovf_d[i];
            res_rng_d[i] = !ovf_d[i]
                        && (cnt_d[i] >= thresh_lo[i*CNT_W +: CNT_W])
                        && (cnt_d[i] <= thresh_hi[i*CNT_W +: CNT_W]);
         end
      end
   end

`ifdef CLK_MON_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = irq_q;
      if (irq_clr) irq_d = 1'b0;
      if (fin && !(&res_rng_d)) irq_d = 1'b1;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) irq_q <= 1'b0;
      else         irq_q <= irq_d;
   end

   assign irq = irq_q;
`endif

   assign busy     = (state_q == S_ARM) || (state_q == S_COUNT);
   assign done     = (state_q == S_DONE);
   assign count    = res_cnt_q;
   assign in_range = res_rng_q;
   assign overflow = res_ovf_q;

endmodule
